// File: rtl/traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_fsm
// Purpose  : Phase controller for a two-way intersection (main / side street)
//            with a pedestrian walk phase. Loads the one-second Timer at the
//            start of every phase and advances on the Timer's expiry pulse.
// Ports    : clk           - 10 kHz system clock (shared with Timer)
//            reset         - asynchronous, active-high
//            sensor        - side-street vehicle present (level)
//            walkRequest   - pedestrian button (level or pulse)
//            expired       - one-cycle Timer expiry pulse
//            startTimer    - one-cycle Timer load strobe
//            timeParameter - interval (seconds) for the current phase
//            mainLight     - {R,Y,G} one-hot, main street
//            sideLight     - {R,Y,G} one-hot, side street
//            walk          - pedestrian walk lamp
// Options  : TRAFFIC_INPUT_SYNC_EN - two-flop synchronizers on sensor and
//            walkRequest (adds two cycles of input latency)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_fsm #(
  parameter logic [6:0] T_BASE = 7'd6,
  parameter logic [6:0] T_EXT  = 7'd3,
  parameter logic [6:0] T_YEL  = 7'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walkRequest,
  input  logic       expired,
  output logic       startTimer,
  output logic [6:0] timeParameter,
  output logic [2:0] mainLight,
  output logic [2:0] sideLight,
  output logic       walk
);

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    WALK     = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_EXT = 3'd4,
    SIDE_Y   = 3'd5
  } state_t;

  localparam logic [2:0] c_RED = 3'b100;
  localparam logic [2:0] c_YEL = 3'b010;
  localparam logic [2:0] c_GRN = 3'b001;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic w_sensor;
  logic w_walk_req;

`ifdef TRAFFIC_INPUT_SYNC_EN
  logic [1:0] sensor_sync_q;
  logic [1:0] walk_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sensor_sync_q <= 2'b00;
      walk_sync_q   <= 2'b00;
    end else begin
      sensor_sync_q <= {sensor_sync_q[0], sensor};
      walk_sync_q   <= {walk_sync_q[0], walkRequest};
    end
  end

  assign w_sensor   = sensor_sync_q[1];
  assign w_walk_req = walk_sync_q[1];
`else
  assign w_sensor   = sensor;
  assign w_walk_req = walkRequest;
`endif

  // --------------------------------------------------------------------------
  // Per-phase decode helpers
  // --------------------------------------------------------------------------
  function automatic logic [6:0] phase_time(input state_t s);
    case (s)
      MAIN_G, SIDE_G: phase_time = T_BASE;
      WALK, SIDE_EXT: phase_time = T_EXT;
      default:        phase_time = T_YEL;
    endcase
  endfunction

  function automatic logic [2:0] main_lamp(input state_t s);
    case (s)
      MAIN_G:  main_lamp = c_GRN;
      MAIN_Y:  main_lamp = c_YEL;
      default: main_lamp = c_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_t s);
    case (s)
      SIDE_G, SIDE_EXT: side_lamp = c_GRN;
      SIDE_Y:           side_lamp = c_YEL;
      default:          side_lamp = c_RED;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t     state_q, state_d, nxt_state;
  logic       start_q, start_d;
  logic [6:0] tparam_q, tparam_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       car_q, car_d;
  logic       walkp_q, walkp_d;

  logic       advance;
  logic       car_eff;
  logic       walk_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MAIN_G;
      start_q  <= 1'b1;        // Timer loads T_BASE on the first edge after release
      tparam_q <= T_BASE;
      main_q   <= c_GRN;
      side_q   <= c_RED;
      walk_q   <= 1'b0;
      car_q    <= 1'b0;
      walkp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      tparam_q <= tparam_d;
      main_q   <= main_d;
      side_q   <= side_d;
      walk_q   <= walk_d;
      car_q    <= car_d;
      walkp_q  <= walkp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // An expiry that coincides with the load strobe belongs to the previous
    // interval and is discarded.
    advance  = expired && !start_q;
    // Requests arriving on the expiry cycle take part in that decision.
    car_eff  = car_q || w_sensor;
    walk_eff = walkp_q || w_walk_req;

    nxt_state = state_q;
    case (state_q)
      MAIN_G:   nxt_state = (car_eff || walk_eff) ? MAIN_Y : MAIN_G;
      MAIN_Y:   nxt_state = walk_eff ? WALK : SIDE_G;
      WALK:     nxt_state = car_eff ? SIDE_G : MAIN_G;
      SIDE_G:   nxt_state = w_sensor ? SIDE_EXT : SIDE_Y;
      SIDE_EXT: nxt_state = SIDE_Y;
      SIDE_Y:   nxt_state = MAIN_G;
      default:  nxt_state = MAIN_G;
    endcase

    state_d  = state_q;
    start_d  = 1'b0;
    tparam_d = tparam_q;
    main_d   = main_q;
    side_d   = side_q;
    walk_d   = walk_q;

    if (advance) begin
      state_d  = nxt_state;
      start_d  = 1'b1;
      tparam_d = phase_time(nxt_state);
      main_d   = main_lamp(nxt_state);
      side_d   = side_lamp(nxt_state);
      walk_d   = (nxt_state == WALK);
    end

    // Clear wins on the entry edge; an input still high afterwards re-sets.
    car_d = car_q;
    if (advance && (nxt_state == SIDE_G)) begin
      car_d = 1'b0;
    end else if (w_sensor) begin
      car_d = 1'b1;
    end

    walkp_d = walkp_q;
    if (advance && (nxt_state == WALK)) begin
      walkp_d = 1'b0;
    end else if (w_walk_req) begin
      walkp_d = 1'b1;
    end
  end

  assign startTimer    = start_q;
  assign timeParameter = tparam_q;
  assign mainLight     = main_q;
  assign sideLight     = side_q;
  assign walk          = walk_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_fsm
// Purpose  : Directed self-checking bench for traffic_phase_fsm. The bench
//            plays the Timer: it pulses expired, queues the expected phase
//            outputs and compares them once the controller has reacted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_fsm;

  logic       clk;
  logic       reset;
  logic       sensor;
  logic       walkRequest;
  logic       expired;
  logic       startTimer;
  logic [6:0] timeParameter;
  logic [2:0] mainLight;
  logic [2:0] sideLight;
  logic       walk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string      tag;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic [6:0] tp;
  } exp_t;

  exp_t sb_q[$];

  traffic_phase_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .sensor       (sensor),
    .walkRequest  (walkRequest),
    .expired      (expired),
    .startTimer   (startTimer),
    .timeParameter(timeParameter),
    .mainLight    (mainLight),
    .sideLight    (sideLight),
    .walk         (walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Safety invariant is checked after every edge.
  task automatic safety();
    n_checks++;
    assert ((mainLight === 3'b100) || (sideLight === 3'b100))
    else begin
      n_err++;
      $error("FAIL safety observed main=%b side=%b expected one red", mainLight, sideLight);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    safety();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Deliver one expiry pulse, queue the phase that should follow, then check
  // the load strobe, the new outputs and that timeParameter holds afterwards.
  task automatic expire(input string tag, input logic [2:0] m, input logic [2:0] s,
                        input logic w, input logic [6:0] tp);
    exp_t e;
    e.tag = tag; e.m = m; e.s = s; e.w = w; e.tp = tp;
    sb_q.push_back(e);
    expired = 1'b1;
    tick();
    expired = 1'b0;
    e = sb_q.pop_front();
    chk({e.tag, ".start"}, startTimer, 1);
    chk({e.tag, ".main"}, mainLight, e.m);
    chk({e.tag, ".side"}, sideLight, e.s);
    chk({e.tag, ".walk"}, walk, e.w);
    chk({e.tag, ".tp"}, timeParameter, e.tp);
    tick();
    chk({e.tag, ".start_drop"}, startTimer, 0);
    chk({e.tag, ".tp_hold"}, timeParameter, e.tp);
  endtask

  initial begin
    reset       = 1'b1;
    sensor      = 1'b0;
    walkRequest = 1'b0;
    expired     = 1'b0;
    ticks(2);

    // Reset state
    chk("rst.start", startTimer, 1);
    chk("rst.tp", timeParameter, 6);
    chk("rst.main", mainLight, 3'b001);
    chk("rst.side", sideLight, 3'b100);
    chk("rst.walk", walk, 0);
    reset = 1'b0;
    #1;
    chk("rel.start", startTimer, 1);
    tick();
    chk("rel.start_drop", startTimer, 0);
    chk("rel.tp", timeParameter, 6);

    // Idle: MAIN_G restarts on every expiry
    expire("idle1", 3'b001, 3'b100, 0, 6);
    expire("idle2", 3'b001, 3'b100, 0, 6);

    // One-cycle sensor pulse: full side cycle without extension
    sensor = 1'b1; tick(); sensor = 1'b0; ticks(3);
    expire("car.my", 3'b010, 3'b100, 0, 2);
    expire("car.sg", 3'b100, 3'b001, 0, 6);
    expire("car.sy", 3'b100, 3'b010, 0, 2);
    expire("car.mg", 3'b001, 3'b100, 0, 6);
    expire("car.idle", 3'b001, 3'b100, 0, 6);

    // Sensor held through side green: one extension only
    sensor = 1'b1; ticks(3);
    expire("ext.my", 3'b010, 3'b100, 0, 2);
    expire("ext.sg", 3'b100, 3'b001, 0, 6);
    expire("ext.se", 3'b100, 3'b001, 0, 3);
    expire("ext.sy", 3'b100, 3'b010, 0, 2);
    sensor = 1'b0; ticks(3);
    expire("ext.mg", 3'b001, 3'b100, 0, 6);
    // sensor stayed high after SIDE_G entry, so a car is still pending
    expire("rep.my", 3'b010, 3'b100, 0, 2);
    expire("rep.sg", 3'b100, 3'b001, 0, 6);
    expire("rep.sy", 3'b100, 3'b010, 0, 2);
    expire("rep.mg", 3'b001, 3'b100, 0, 6);
    expire("rep.idle", 3'b001, 3'b100, 0, 6);

    // Pedestrian phase
    walkRequest = 1'b1; tick(); walkRequest = 1'b0; ticks(3);
    expire("ped.my", 3'b010, 3'b100, 0, 2);
    expire("ped.wk", 3'b100, 3'b100, 1, 3);
    expire("ped.mg", 3'b001, 3'b100, 0, 6);
    expire("ped.idle", 3'b001, 3'b100, 0, 6);

    // Stale expiry coinciding with the load strobe is ignored
    walkRequest = 1'b1; tick(); walkRequest = 1'b0; ticks(3);
    sb_q.push_back('{tag: "stale.my", m: 3'b010, s: 3'b100, w: 1'b0, tp: 7'd2});
    expired = 1'b1;
    tick();
    begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".start"}, startTimer, 1);
      chk({e.tag, ".main"}, mainLight, e.m);
      // expired still high while startTimer=1
      tick();
      expired = 1'b0;
      chk("stale.start_drop", startTimer, 0);
      chk("stale.main_hold", mainLight, e.m);
      chk("stale.tp_hold", timeParameter, e.tp);
    end
    ticks(2);
    chk("stale.main_hold2", mainLight, 3'b010);
    expire("stale.wk", 3'b100, 3'b100, 1, 3);
    expire("stale.mg", 3'b001, 3'b100, 0, 6);

`ifndef TRAFFIC_INPUT_SYNC_EN
    // Sensor arriving on the expiry cycle counts for that decision
    sensor = 1'b1;
    expire("sim.my", 3'b010, 3'b100, 0, 2);
    sensor = 1'b0;
    expire("sim.sg", 3'b100, 3'b001, 0, 6);
    expire("sim.sy", 3'b100, 3'b010, 0, 2);
    expire("sim.mg", 3'b001, 3'b100, 0, 6);
`else
    // Synchronizer latency: a pulse one cycle before expiry is not yet seen
    sensor = 1'b1; tick(); sensor = 1'b0;
    expire("sync.mg", 3'b001, 3'b100, 0, 6);
    ticks(2);
    expire("sync.my", 3'b010, 3'b100, 0, 2);
    expire("sync.sg", 3'b100, 3'b001, 0, 6);
    expire("sync.sy", 3'b100, 3'b010, 0, 2);
    expire("sync.mg2", 3'b001, 3'b100, 0, 6);
`endif

    // Reset in the middle of SIDE_G, with a walk request pending
    sensor = 1'b1; tick(); sensor = 1'b0; ticks(3);
    expire("mid.my", 3'b010, 3'b100, 0, 2);
    expire("mid.sg", 3'b100, 3'b001, 0, 6);
    walkRequest = 1'b1; tick(); walkRequest = 1'b0; ticks(3);
    reset = 1'b1;
    #1;
    chk("mid.rst_main", mainLight, 3'b001);
    chk("mid.rst_side", sideLight, 3'b100);
    chk("mid.rst_start", startTimer, 1);
    chk("mid.rst_tp", timeParameter, 6);
    tick();
    reset = 1'b0;
    tick();
    chk("mid.start_drop", startTimer, 0);
    ticks(2);
    // walkPending was lost by the reset
    expire("mid.idle", 3'b001, 3'b100, 0, 6);

    chk("sb.empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
